// File: rtl/uart_prog_loader.sv
// UART boot loader: receives SYNC/LEN/data/CSUM frames and writes the image into
// program memory, releasing the core (cpu_run) after a matching checksum.
module uart_prog_loader #(
  parameter int         CLKS_PER_BIT = 217,
  parameter int         MEM_SIZE     = 256,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       prog_we,
  output logic [7:0] prog_addr,
  output logic [7:0] prog_wdata,
  output logic       cpu_run,
  output logic       load_done,
  output logic       load_err
);
  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {WAIT_SYNC, GET_LEN, GET_DATA, GET_CSUM, RUN} ld_state_t;

  // ---------------- RX front end ----------------
  logic            rx_meta_q, rx_meta_d, rx_s_q, rx_s_d, rx_prev_q, rx_prev_d;
  rx_state_t       rs_q, rs_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic            rx_valid, frame_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      rs_q      <= RX_IDLE;
      tmr_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      rx_prev_q <= rx_prev_d;
      rs_q      <= rs_d;
      tmr_q     <= tmr_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
    end
  end

  always_comb begin
    rx_meta_d = uart_rx;
    rx_s_d    = rx_meta_q;
    rx_prev_d = rx_s_q;
    rs_d      = rs_q;
    tmr_d     = tmr_q + 1'b1;
    bit_d     = bit_q;
    sh_d      = sh_q;
    rx_valid  = 1'b0;
    frame_err = 1'b0;
    case (rs_q)
      RX_IDLE: begin
        tmr_d = '0;
        if (!rx_s_q && rx_prev_q) rs_d = RX_START;
      end
      RX_START: if (tmr_q == HALF) begin
        tmr_d = '0;
        bit_d = '0;
        rs_d  = rx_s_q ? RX_IDLE : RX_DATA;  // high at centre = glitch
      end
      RX_DATA: if (tmr_q == FULL) begin
        tmr_d = '0;
        sh_d  = {rx_s_q, sh_q[7:1]};
        bit_d = 3'(bit_q + 3'd1);
        if (bit_q == 3'd7) rs_d = RX_STOP;
      end
      RX_STOP: if (tmr_q == FULL) begin
        rs_d      = RX_IDLE;
        rx_valid  = rx_s_q;
        frame_err = !rx_s_q;
      end
      default: rs_d = RX_IDLE;
    endcase
  end

  // ---------------- Frame loader ----------------
  ld_state_t  st_q, st_d;
  logic [8:0] cnt_q, cnt_d;
  logic [7:0] csum_q, csum_d, addr_q, addr_d, wdata_q, wdata_d;
  logic       we_q, we_d, run_q, run_d, done_q, done_d, err_q, err_d;
  logic       sync_seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= WAIT_SYNC;
      cnt_q   <= '0;
      csum_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      run_q   <= run_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign sync_seen = rx_valid && (sh_q == SYNC_BYTE);

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    run_d   = run_q;
    done_d  = done_q;
    err_d   = err_q;
    // Address advances the cycle after each strobe, wrapping at 8 bits.
    if (we_q) addr_d = addr_q + 8'd1;
    case (st_q)
      WAIT_SYNC, RUN: if (sync_seen) begin
        st_d   = GET_LEN;
        err_d  = 1'b0;
        done_d = 1'b0;
        run_d  = 1'b0;
        csum_d = '0;
        addr_d = '0;
      end
      GET_LEN: if (rx_valid) begin
        cnt_d = (sh_q == 8'd0) ? 9'(MEM_SIZE) : {1'b0, sh_q};
        st_d  = GET_DATA;
      end
      GET_DATA: if (rx_valid) begin
        wdata_d = sh_q;
        we_d    = 1'b1;
        csum_d  = csum_q + sh_q;
        cnt_d   = cnt_q - 9'd1;
        if (cnt_q == 9'd1) st_d = GET_CSUM;
      end
      GET_CSUM: if (rx_valid) begin
        if (sh_q == csum_q) begin
          st_d   = RUN;
          done_d = 1'b1;
          run_d  = 1'b1;
        end else begin
          st_d  = WAIT_SYNC;
          err_d = 1'b1;
        end
      end
      default: st_d = WAIT_SYNC;
    endcase
    if (frame_err && (st_q == GET_LEN || st_q == GET_DATA || st_q == GET_CSUM)) begin
      st_d  = WAIT_SYNC;
      err_d = 1'b1;
    end
  end

  assign prog_we    = we_q;
  assign prog_addr  = addr_q;
  assign prog_wdata = wdata_q;
  assign cpu_run    = run_q;
  assign load_done  = done_q;
  assign load_err   = err_q;
endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: serial frames driven bit by bit, writes captured
// from the strobe port and compared with a queue-based frame model.
module tb_uart_prog_loader;
  localparam int CPB = 8;

  logic       clk = 1'b0, rst = 1'b1, uart_rx = 1'b1;
  logic       prog_we, cpu_run, load_done, load_err;
  logic [7:0] prog_addr, prog_wdata;
  int         chk_cnt = 0, pass_cnt = 0;
  logic [7:0] wa[$], wd[$];

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .MEM_SIZE(256), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .cpu_run(cpu_run), .load_done(load_done), .load_err(load_err));

  always #5 clk = ~clk;

  always @(negedge clk) if (prog_we === 1'b1) begin
    wa.push_back(prog_addr);
    wd.push_back(prog_wdata);
  end

  function automatic logic [7:0] sum8(input logic [7:0] q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return 8'(s);
  endfunction

  task automatic idle(input int bits);
    uart_rx = 1'b1;
    repeat (bits * CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d[$], input logic [7:0] csum);
    send_byte(8'hA5);
    send_byte(8'(d.size()));
    foreach (d[i]) send_byte(d[i]);
    send_byte(csum);
    idle(3);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk_cnt++;
    if ({prog_we, prog_addr, prog_wdata, cpu_run, load_done, load_err} !== 20'd0)
      $display("FAIL reset_outputs got we=%b addr=%h wd=%h run=%b done=%b err=%b want all 0",
               prog_we, prog_addr, prog_wdata, cpu_run, load_done, load_err);
    else pass_cnt++;
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_good_frame;
    logic [7:0] d[$];
    for (int f = 0; f < 4; f++) begin
      d.delete();
      if (f == 0) d = '{8'h12, 8'h34, 8'h56, 8'h78};
      else for (int i = 0; i < int'($urandom_range(1, 12)); i++) d.push_back(8'($urandom));
      wa.delete(); wd.delete();
      send_frame(d, sum8(d));
      chk_cnt++;
      if (wa.size() != d.size()) $display("FAIL good_nwrites f%0d got %0d want %0d", f, wa.size(), d.size());
      else pass_cnt++;
      for (int i = 0; i < d.size() && i < wa.size(); i++) begin
        chk_cnt++;
        if ({wa[i], wd[i]} !== {8'(i), d[i]})
          $display("FAIL good_write f%0d[%0d] got %h:%h want %h:%h", f, i, wa[i], wd[i], 8'(i), d[i]);
        else pass_cnt++;
      end
      chk_cnt++;
      if ({load_done, cpu_run, load_err} !== 3'b110 || prog_addr !== 8'(d.size()))
        $display("FAIL good_status f%0d got done=%b run=%b err=%b addr=%h want 1 1 0 %h",
                 f, load_done, cpu_run, load_err, prog_addr, 8'(d.size()));
      else pass_cnt++;
    end
  endtask

  task automatic test_bad_csum;
    logic [7:0] d[$];
    d = '{8'h12, 8'h34, 8'h56, 8'h78};
    wa.delete(); wd.delete();
    send_frame(d, 8'h15);
    chk_cnt++;
    if (wa.size() != 4 || wd.size() != 4 || wd[3] !== 8'h78)
      $display("FAIL badcsum_writes got n=%0d want 4 ending 78", wa.size());
    else pass_cnt++;
    chk_cnt++;
    if ({load_done, cpu_run, load_err} !== 3'b001)
      $display("FAIL badcsum_status got done=%b run=%b err=%b want 0 0 1", load_done, cpu_run, load_err);
    else pass_cnt++;
  endtask

  task automatic test_glitch;
    logic [7:0] d[$];
    wa.delete(); wd.delete();
    uart_rx = 1'b0;
    repeat (CPB * 3 / 10) @(negedge clk);
    idle(2);
    send_byte(8'h00);
    send_byte(8'hFF);
    idle(2);
    chk_cnt++;
    if (wa.size() != 0 || {load_done, cpu_run, load_err} !== 3'b001)
      $display("FAIL glitch_ignored got n=%0d done=%b run=%b err=%b want 0 0 0 1",
               wa.size(), load_done, cpu_run, load_err);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) d.push_back(8'($urandom));
    send_frame(d, sum8(d));
    chk_cnt++;
    if (wa.size() != 5 || wd[4] !== d[4] || {load_done, cpu_run, load_err} !== 3'b110)
      $display("FAIL glitch_then_load got n=%0d done=%b run=%b err=%b want 5 1 1 0",
               wa.size(), load_done, cpu_run, load_err);
    else pass_cnt++;
  endtask

  task automatic test_full_256;
    logic [7:0] d[$];
    int bad = 0;
    for (int i = 0; i < 256; i++) d.push_back(8'h01);
    wa.delete(); wd.delete();
    send_frame(d, 8'h00);
    chk_cnt++;
    if (wa.size() != 256) $display("FAIL full_nwrites got %0d want 256", wa.size());
    else pass_cnt++;
    for (int i = 0; i < wa.size(); i++) if ({wa[i], wd[i]} !== {8'(i), 8'h01}) bad++;
    chk_cnt++;
    if (bad != 0) $display("FAIL full_writes got %0d bad entries want 0", bad);
    else pass_cnt++;
    chk_cnt++;
    if (prog_addr !== 8'h00 || {load_done, cpu_run, load_err} !== 3'b110)
      $display("FAIL full_status got addr=%h done=%b run=%b err=%b want 00 1 1 0",
               prog_addr, load_done, cpu_run, load_err);
    else pass_cnt++;
  endtask

  task automatic test_frame_err;
    logic [7:0] d[$];
    wa.delete(); wd.delete();
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h5A);
    send_byte(8'hC3, 1'b0);
    idle(3);
    chk_cnt++;
    if (wa.size() != 1 || wd[0] !== 8'h5A || {load_done, cpu_run, load_err} !== 3'b001)
      $display("FAIL frameerr_abort got n=%0d done=%b run=%b err=%b want 1 0 0 1",
               wa.size(), load_done, cpu_run, load_err);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) d.push_back(8'($urandom));
    send_frame(d, sum8(d));
    chk_cnt++;
    if ({load_done, cpu_run, load_err} !== 3'b110)
      $display("FAIL frameerr_recover got done=%b run=%b err=%b want 1 1 0", load_done, cpu_run, load_err);
    else pass_cnt++;
    // Reload from RUN: send the frame in pieces to observe cpu_run dropping.
    d.delete();
    for (int i = 0; i < 6; i++) d.push_back(8'($urandom));
    wa.delete(); wd.delete();
    send_byte(8'hA5);
    idle(2);
    chk_cnt++;
    if ({cpu_run, load_done} !== 2'b00)
      $display("FAIL reload_drop got run=%b done=%b want 0 0", cpu_run, load_done);
    else pass_cnt++;
    send_byte(8'd6);
    foreach (d[i]) send_byte(d[i]);
    send_byte(sum8(d));
    idle(3);
    chk_cnt++;
    if (wa.size() != 6 || wd[5] !== d[5] || wa[5] !== 8'd5 || {load_done, cpu_run} !== 2'b11)
      $display("FAIL reload_done got n=%0d done=%b run=%b want 6 1 1", wa.size(), load_done, cpu_run);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    logic [7:0] d[$];
    send_byte(8'hA5);
    send_byte(8'h08);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    uart_rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    chk_cnt++;
    if (prog_addr !== 8'd3) $display("FAIL midframe_addr got %h want 03", prog_addr);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    chk_cnt++;
    if ({prog_we, prog_addr, prog_wdata, cpu_run, load_done, load_err} !== 20'd0)
      $display("FAIL async_reset got addr=%h wd=%h run=%b done=%b err=%b want all 0",
               prog_addr, prog_wdata, cpu_run, load_done, load_err);
    else pass_cnt++;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(2);
    for (int i = 0; i < 7; i++) d.push_back(8'($urandom));
    wa.delete(); wd.delete();
    send_frame(d, sum8(d));
    chk_cnt++;
    if (wa.size() != 7 || wa[0] !== 8'd0 || wd[6] !== d[6] || {load_done, cpu_run, load_err} !== 3'b110)
      $display("FAIL post_reset_load got n=%0d done=%b run=%b err=%b want 7 1 1 0",
               wa.size(), load_done, cpu_run, load_err);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] a[$], b[$];
    for (int i = 0; i < 3; i++) a.push_back(8'($urandom));
    for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
    wa.delete(); wd.delete();
    send_byte(8'hA5); send_byte(8'd3);
    foreach (a[i]) send_byte(a[i]);
    send_byte(sum8(a) ^ 8'h80);
    send_byte(8'hA5); send_byte(8'd4);
    foreach (b[i]) send_byte(b[i]);
    send_byte(sum8(b));
    idle(3);
    chk_cnt++;
    if (wa.size() != 7 || wa[3] !== 8'd0 || wd[6] !== b[3] || {load_done, cpu_run, load_err} !== 3'b110)
      $display("FAIL back_to_back got n=%0d done=%b run=%b err=%b want 7 1 1 0",
               wa.size(), load_done, cpu_run, load_err);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_glitch();
    test_full_256();
    test_frame_err();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
